// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg -- shared constants for the tick generator.
//   NB_SEL            width of the rate-select field
//   ST_IDLE / ST_RUN  FSM state encodings (1-bit, legacy-compatible)
//   LIMIT_n_DEFAULT   default tick periods in clocks for each rate select
//   limit_in_range()  elaboration-time legality test for a LIMIT value
package tick_gen_pkg;

  localparam int NB_SEL   = 2;
  localparam int NB_STATE = 1;

  typedef logic [NB_SEL-1:0]   sel_t;
  typedef logic [NB_STATE-1:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  localparam int unsigned LIMIT_0_DEFAULT = 25_000_000;
  localparam int unsigned LIMIT_1_DEFAULT = 50_000_000;
  localparam int unsigned LIMIT_2_DEFAULT = 75_000_000;
  localparam int unsigned LIMIT_3_DEFAULT = 100_000_000;

  // A period must be at least 2 clocks (so a pulse is never back-to-back)
  // and must fit in an nb-bit counter.
  function automatic bit limit_in_range(input longint unsigned lim, input int nb);
    return (lim >= 64'd2) && (lim <= ((64'd1 << nb) - 64'd1));
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if -- switch inputs, tick outputs and debug view of tick_gen.
//   i_enable      run/pause switch (asynchronous to clock)
//   i_sel         rate-select switches (asynchronous to clock)
//   o_valid       one-clock tick strobe
//   o_sel_active  rate currently in effect
//   o_running     high while the FSM is in ST_RUN
//   dbg_state     FSM state register
//   dbg_cnt       prescaler counter
// Handshake: o_valid is a strobe with no ready; the consumer must accept it
// on the single cycle it is high, there is no back-pressure.
interface tick_gen_if import tick_gen_pkg::*; #(
  parameter int NB_COUNTER = 32
) ();

  logic                  i_enable;
  sel_t                  i_sel;
  logic                  o_valid;
  sel_t                  o_sel_active;
  logic                  o_running;
  state_t                dbg_state;
  logic [NB_COUNTER-1:0] dbg_cnt;

  modport master (
    output i_enable, i_sel,
    input  o_valid, o_sel_active, o_running, dbg_state, dbg_cnt
  );

  modport slave (
    input  i_enable, i_sel,
    output o_valid, o_sel_active, o_running, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/tick_gen_sync_2ff.sv
// sync_2ff -- two-flop synchronizer for slow asynchronous level inputs.
//   clock    destination clock
//   i_reset  synchronous, active-high; clears both stages to 0
//   d        asynchronous input bus
//   q        synchronized output, two clocks behind d
// Each bit is synchronized independently; the inputs are switches, so a
// multi-bit skew of one clock is harmless.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen -- selectable-rate tick generator with run/pause control.
//   clock    system clock, all state on its rising edge
//   i_reset  synchronous, active-high, overrides everything
//   bus      tick_gen_if.slave: i_enable, i_sel in; o_valid, o_sel_active,
//            o_running, dbg_state, dbg_cnt out (all registered)
// Emits a one-clock o_valid pulse every LIMIT_<sel> clocks while enabled.
// Pausing holds the counter; changing the rate restarts the period.
module tick_gen import tick_gen_pkg::*; #(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = LIMIT_0_DEFAULT,
  parameter int unsigned LIMIT_1    = LIMIT_1_DEFAULT,
  parameter int unsigned LIMIT_2    = LIMIT_2_DEFAULT,
  parameter int unsigned LIMIT_3    = LIMIT_3_DEFAULT
) (
  input  logic     clock,
  input  logic     i_reset,
  tick_gen_if.slave bus
);

  if (NB_COUNTER < 2 || NB_COUNTER > 63) begin : g_bad_width
    $error("tick_gen: NB_COUNTER must be in [2, 63]");
  end

  if (!(limit_in_range(64'(LIMIT_0), NB_COUNTER) &&
        limit_in_range(64'(LIMIT_1), NB_COUNTER) &&
        limit_in_range(64'(LIMIT_2), NB_COUNTER) &&
        limit_in_range(64'(LIMIT_3), NB_COUNTER))) begin : g_bad_limit
    $error("tick_gen: every LIMIT_n must be in [2, 2^NB_COUNTER-1]");
  end

  // Terminal counts (period - 1) precomputed at elaboration.
  localparam logic [NB_COUNTER-1:0] LAST_0 = NB_COUNTER'(LIMIT_0 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_1 = NB_COUNTER'(LIMIT_1 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_2 = NB_COUNTER'(LIMIT_2 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_3 = NB_COUNTER'(LIMIT_3 - 1);

  logic [NB_SEL:0]         sync_q;
  logic                    en_s;
  sel_t                    sel_s;
  logic [NB_COUNTER-1:0]   last;
  state_t                  state;
  state_t                  state_next;
  logic [NB_COUNTER-1:0]   cnt;
  logic                    valid;
  logic                    running;
  sel_t                    sel_active;

  sync_2ff #(
    .WIDTH (NB_SEL + 1)
  ) u_sync (
    .clock   (clock),
    .i_reset (i_reset),
    .d       ({bus.i_enable, bus.i_sel}),
    .q       (sync_q)
  );

  assign en_s  = sync_q[NB_SEL];
  assign sel_s = sync_q[NB_SEL-1:0];

  always_comb begin
    last = LAST_0;
    case (sel_s)
      2'd1:    last = LAST_1;
      2'd2:    last = LAST_2;
      2'd3:    last = LAST_3;
      default: last = LAST_0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en_s)  state_next = ST_RUN;
      ST_RUN:  if (!en_s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      cnt        <= '0;
      valid      <= 1'b0;
      sel_active <= '0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
      // A rate change restarts the period and suppresses any pulse that
      // would otherwise have fired on this edge, in either state.
      if (sel_s != sel_active) begin
        cnt        <= '0;
        valid      <= 1'b0;
        sel_active <= sel_s;
      end else if (state == ST_RUN) begin
        // >= rather than == so a counter left above the limit recovers.
        if (cnt >= last) begin
          cnt   <= '0;
          valid <= 1'b1;
        end else begin
          cnt   <= cnt + NB_COUNTER'(1);
          valid <= 1'b0;
        end
      end else begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.o_valid      = valid;
  assign bus.o_sel_active = sel_active;
  assign bus.o_running    = running;
  assign bus.dbg_state    = state;
  assign bus.dbg_cnt      = cnt;

endmodule
